// File: rtl/mtimer_pkg.sv
// Shared definitions for the memory-mapped machine timer: register selects,
// CTRL bit positions, reset values and the byte-lane merge helper.
package mtimer_pkg;

  // Register select is bus_addr[4:2]; bus_addr[5] set means unmapped
  typedef enum logic [2:0] {
    REG_MTIME_LO    = 3'd0,
    REG_MTIME_HI    = 3'd1,
    REG_MTIMECMP_LO = 3'd2,
    REG_MTIMECMP_HI = 3'd3,
    REG_CTRL        = 3'd4,
    REG_PRESCALE    = 3'd5,
    REG_MTIME_SNAP  = 3'd6,
    REG_NONE        = 3'd7
  } reg_e;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [15:0] PRESCALE_RST = 16'h0000;

  function automatic logic [31:0] apply_be(input logic [31:0] old,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Free-running prescale counter: one tick every prescale+1 enabled cycles.
module mtimer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] prescale,
  output logic        tick
);

  logic [15:0] pcnt;

  assign tick = en && (pcnt == prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (clr || tick) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= pcnt + 16'd1;
    end
  end

endmodule

// File: rtl/mtimer.sv
// RISC-V machine timer on the data bus: 64-bit mtime/mtimecmp, prescaler,
// tear-free high-word snapshot and a registered timer interrupt level.
module mtimer
  import mtimer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int unsigned XLEN      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   bus_addr,
  input  logic              bus_rd,
  input  logic              bus_wr,
  input  logic [XLEN/8-1:0] bus_be,
  input  logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN-1:0]   bus_rdata,
  output logic              bus_hit,
  output logic              bus_fault,
  output logic              timer
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        en;
  logic [15:0] prescale;
  logic [31:0] snap;
  logic        tick;
  logic [31:0] rdata_nx;
  reg_e        sel;
  logic        mapped;
  logic        wr_ok;
  logic        rd_ok;

  assign sel       = reg_e'(bus_addr[4:2]);
  assign bus_hit   = (bus_addr[31:6] == BASE_ADDR[31:6]);
  assign mapped    = !bus_addr[5] && (sel != REG_NONE) && (bus_addr[1:0] == 2'b00);
  assign bus_fault = bus_hit && !mapped;
  assign wr_ok     = bus_wr && bus_hit && mapped;
  assign rd_ok     = bus_rd && bus_hit;

  mtimer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (wr_ok && (sel == REG_PRESCALE)),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    rdata_nx = '0;
    if (mapped) begin
      case (sel)
        REG_MTIME_LO:    rdata_nx = mtime[31:0];
        REG_MTIME_HI:    rdata_nx = mtime[63:32];
        REG_MTIMECMP_LO: rdata_nx = mtimecmp[31:0];
        REG_MTIMECMP_HI: rdata_nx = mtimecmp[63:32];
        REG_CTRL:        rdata_nx[CTRL_EN_BIT] = en;
        REG_PRESCALE:    rdata_nx[15:0] = prescale;
        REG_MTIME_SNAP:  rdata_nx = snap;
        default:         rdata_nx = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime     <= '0;
      mtimecmp  <= MTIMECMP_RST;
      en        <= 1'b1;
      prescale  <= PRESCALE_RST;
      snap      <= '0;
      bus_rdata <= '0;
      timer     <= 1'b0;
    end else begin
      // A write to either mtime half suppresses the tick for the whole 64 bits
      if (wr_ok && (sel == REG_MTIME_LO)) begin
        mtime[31:0] <= apply_be(mtime[31:0], bus_wdata, bus_be);
      end else if (wr_ok && (sel == REG_MTIME_HI)) begin
        mtime[63:32] <= apply_be(mtime[63:32], bus_wdata, bus_be);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      if (wr_ok) begin
        case (sel)
          REG_MTIMECMP_LO: mtimecmp[31:0]  <= apply_be(mtimecmp[31:0], bus_wdata, bus_be);
          REG_MTIMECMP_HI: mtimecmp[63:32] <= apply_be(mtimecmp[63:32], bus_wdata, bus_be);
          REG_CTRL: begin
            if (bus_be[0]) en <= bus_wdata[CTRL_EN_BIT];
          end
          REG_PRESCALE: begin
            if (bus_be[0]) prescale[7:0]  <= bus_wdata[7:0];
            if (bus_be[1]) prescale[15:8] <= bus_wdata[15:8];
          end
          default: ;
        endcase
      end

      if (rd_ok) begin
        bus_rdata <= rdata_nx;
        if (mapped && (sel == REG_MTIME_LO)) snap <= mtime[63:32];
      end

      timer <= en && (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_mtimer.sv
// Directed testbench for mtimer: register map, prescaler, carry/wrap,
// byte-masked writes, snapshot, bus decode faults and asynchronous reset.
module tb_mtimer;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk;
  logic        rst;
  logic [31:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_hit;
  logic        bus_fault;
  logic        timer;

  int total;
  int bad;

  mtimer #(.BASE_ADDR(BASE), .XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_hit   (bus_hit),
    .bus_fault (bus_fault),
    .timer     (timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; the access is sampled by the following posedge.
  task automatic bus_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] be);
    bus_addr  = BASE + {24'h0, off};
    bus_wdata = data;
    bus_be    = be;
    bus_wr    = 1'b1;
    @(negedge clk);
    bus_wr    = 1'b0;
    bus_be    = 4'h0;
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [31:0] data);
    bus_addr = BASE + {24'h0, off};
    bus_rd   = 1'b1;
    @(negedge clk);
    bus_rd   = 1'b0;
    data     = bus_rdata;
  endtask

  task automatic test_reset();
    total++;
    if (bus_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got %h want %h", bus_rdata, 32'h0);
    end
    total++;
    if (timer !== 1'b0) begin
      bad++; $display("FAIL reset_timer: got %b want 0", timer);
    end
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_release_rdata: got %h want %h", bus_rdata, 32'h0);
    end
  endtask

  task automatic test_idle();
    logic [31:0] d;
    repeat (10) @(negedge clk);
    bus_read(8'h00, d);
    total++;
    if (d !== 32'd10) begin
      bad++; $display("FAIL idle_mtime_lo: got %0d want 10", d);
    end
    total++;
    if (timer !== 1'b0) begin
      bad++; $display("FAIL idle_timer: got %b want 0", timer);
    end
    bus_read(8'h10, d);
    total++;
    if (d !== 32'h1) begin
      bad++; $display("FAIL reset_ctrl: got %h want 1", d);
    end
    bus_read(8'h14, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL reset_prescale: got %h want 0", d);
    end
    bus_read(8'h0C, d);
    total++;
    if (d !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL reset_cmp_hi: got %h want ffffffff", d);
    end
  endtask

  task automatic test_compare();
    bus_write(8'h10, 32'h0, 4'hF);
    bus_write(8'h00, 32'h0, 4'hF);
    bus_write(8'h04, 32'h0, 4'hF);
    bus_write(8'h0C, 32'h0, 4'hF);
    bus_write(8'h08, 32'd20, 4'hF);
    bus_write(8'h10, 32'h1, 4'hF);
    // mtime equals k after k further edges; timer follows one edge later
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      total++;
      if (timer !== (k >= 21)) begin
        bad++; $display("FAIL cmp_rise_k%0d: got %b want %b", k, timer, (k >= 21));
      end
    end
    bus_write(8'h08, 32'hFFFF_FFFF, 4'hF);
    total++;
    if (timer !== 1'b1) begin
      bad++; $display("FAIL cmp_fall_same: got %b want 1", timer);
    end
    @(negedge clk);
    total++;
    if (timer !== 1'b0) begin
      bad++; $display("FAIL cmp_fall_next: got %b want 0", timer);
    end
  endtask

  task automatic test_prescale();
    logic [31:0] a;
    logic [31:0] b;
    bus_write(8'h14, 32'hABCD_0003, 4'hF);
    bus_read(8'h14, a);
    total++;
    if (a !== 32'h3) begin
      bad++; $display("FAIL prescale_readback: got %h want 3", a);
    end
    bus_read(8'h00, a);
    repeat (39) @(negedge clk);
    bus_read(8'h00, b);
    total++;
    if ((b - a) !== 32'd10) begin
      bad++; $display("FAIL prescale_40cyc: got %0d want 10", b - a);
    end
    bus_write(8'h08, 32'h0, 4'hF);
    @(negedge clk);
    total++;
    if (timer !== 1'b1) begin
      bad++; $display("FAIL cmp_zero_timer: got %b want 1", timer);
    end
    bus_write(8'h10, 32'h0, 4'hF);
    @(negedge clk);
    total++;
    if (timer !== 1'b0) begin
      bad++; $display("FAIL en_off_timer: got %b want 0", timer);
    end
    bus_read(8'h00, a);
    repeat (5) @(negedge clk);
    bus_read(8'h00, b);
    total++;
    if (b !== a) begin
      bad++; $display("FAIL en_off_frozen: got %h want %h", b, a);
    end
    bus_read(8'h10, a);
    total++;
    if (a !== 32'h0) begin
      bad++; $display("FAIL ctrl_readback: got %h want 0", a);
    end
  endtask

  task automatic test_carry();
    logic [31:0] d;
    bus_write(8'h14, 32'h0, 4'hF);
    bus_write(8'h00, 32'hFFFF_FFFE, 4'hF);
    bus_write(8'h04, 32'h1, 4'hF);
    bus_write(8'h10, 32'h1, 4'hF);
    @(negedge clk);
    bus_write(8'h10, 32'h0, 4'hF);
    bus_read(8'h00, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL carry_lo: got %h want 0", d);
    end
    bus_read(8'h04, d);
    total++;
    if (d !== 32'h2) begin
      bad++; $display("FAIL carry_hi: got %h want 2", d);
    end
    bus_write(8'h00, 32'hFFFF_FFFE, 4'hF);
    bus_write(8'h04, 32'hFFFF_FFFF, 4'hF);
    bus_write(8'h10, 32'h1, 4'hF);
    @(negedge clk);
    bus_write(8'h10, 32'h0, 4'hF);
    bus_read(8'h00, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL wrap_lo: got %h want 0", d);
    end
    bus_read(8'h04, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL wrap_hi: got %h want 0", d);
    end
  endtask

  task automatic test_bytemask();
    logic [31:0] d;
    bus_write(8'h00, 32'h1111_2222, 4'hF);
    bus_write(8'h04, 32'h0, 4'hF);
    bus_write(8'h10, 32'h1, 4'hF);
    bus_write(8'h00, 32'hAAAA_5555, 4'b0011);
    bus_write(8'h10, 32'h0, 4'hF);
    // masked write replaces the tick, then one more tick before EN drops
    bus_read(8'h00, d);
    total++;
    if (d !== 32'h1111_5556) begin
      bad++; $display("FAIL bytemask_lo: got %h want 11115556", d);
    end
    bus_read(8'h04, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL bytemask_hi: got %h want 0", d);
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] d;
    bus_write(8'h00, 32'hFFFF_FFFF, 4'hF);
    bus_write(8'h04, 32'h7, 4'hF);
    bus_read(8'h00, d);
    total++;
    if (d !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL snap_lo_read: got %h want ffffffff", d);
    end
    bus_write(8'h10, 32'h1, 4'hF);
    bus_write(8'h10, 32'h0, 4'hF);
    bus_read(8'h18, d);
    total++;
    if (d !== 32'h7) begin
      bad++; $display("FAIL snap_value: got %h want 7", d);
    end
    bus_read(8'h04, d);
    total++;
    if (d !== 32'h8) begin
      bad++; $display("FAIL snap_live_hi: got %h want 8", d);
    end
    repeat (2) @(negedge clk);
    bus_addr = 32'h0000_1000;
    bus_rd   = 1'b1;
    @(negedge clk);
    bus_rd   = 1'b0;
    total++;
    if (bus_rdata !== 32'h8) begin
      bad++; $display("FAIL rdata_hold: got %h want 8", bus_rdata);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    bus_addr  = BASE + 32'h08;
    bus_wdata = 32'h55;
    bus_be    = 4'hF;
    bus_rd    = 1'b1;
    bus_wr    = 1'b1;
    @(negedge clk);
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    total++;
    if (bus_rdata !== 32'h0) begin
      bad++; $display("FAIL rw_old_data: got %h want 0", bus_rdata);
    end
    bus_read(8'h08, d);
    total++;
    if (d !== 32'h55) begin
      bad++; $display("FAIL rw_write_applied: got %h want 55", d);
    end
  endtask

  task automatic test_fault();
    logic [31:0] d;
    logic [31:0] addrs [5];
    logic        exp_hit [5];
    logic        exp_flt [5];
    addrs = '{BASE + 32'h20, BASE + 32'h02, BASE + 32'h1C, BASE + 32'h18, BASE - 32'h4};
    exp_hit = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_flt = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus_addr  = addrs[i];
      bus_wdata = 32'hDEAD_BEEF;
      bus_be    = 4'hF;
      bus_wr    = 1'b1;
      #1;
      total++;
      if (bus_hit !== exp_hit[i] || bus_fault !== exp_flt[i]) begin
        bad++;
        $display("FAIL decode_%0d: got hit=%b fault=%b want hit=%b fault=%b",
                 i, bus_hit, bus_fault, exp_hit[i], exp_flt[i]);
      end
      @(negedge clk);
      bus_wr = 1'b0;
    end
    bus_read(8'h00, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL fault_lo_unchanged: got %h want 0", d);
    end
    bus_read(8'h04, d);
    total++;
    if (d !== 32'h8) begin
      bad++; $display("FAIL fault_hi_unchanged: got %h want 8", d);
    end
    bus_read(8'h20, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL unmapped_read: got %h want 0", d);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    bus_write(8'h08, 32'h0, 4'hF);
    bus_write(8'h10, 32'h1, 4'hF);
    repeat (2) @(negedge clk);
    total++;
    if (timer !== 1'b1) begin
      bad++; $display("FAIL pre_reset_timer: got %b want 1", timer);
    end
    bus_read(8'h04, d);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (timer !== 1'b0 || bus_rdata !== 32'h0) begin
      bad++; $display("FAIL async_reset: got timer=%b rdata=%h want timer=0 rdata=0", timer, bus_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_read(8'h0C, d);
    total++;
    if (d !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL post_reset_cmp_hi: got %h want ffffffff", d);
    end
    bus_read(8'h10, d);
    total++;
    if (d !== 32'h1) begin
      bad++; $display("FAIL post_reset_ctrl: got %h want 1", d);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus_addr  = '0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_be    = '0;
    bus_wdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_idle();
    test_compare();
    test_prescale();
    test_carry();
    test_bytemask();
    test_snapshot();
    test_collision();
    test_fault();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mtimer.md
Name: mtimer

Overview:
- Memory-mapped RISC-V machine timer. Owns 64-bit mtime/mtimecmp and drives the `timer` pending level into the core's interrupt controller, which samples it into MIP.MTIP.
- Sits on the data bus beside RAM/IO and decodes its own address window.
- Adds a programmable prescaler and an atomic 64-bit read snapshot.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00, byte address of register window (64-byte aligned).
- XLEN, 32, bus data width; fixed at 32, no other value supported.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- bus_addr  input  32  byte address
- bus_rd  input  1  read strobe, one cycle per access
- bus_wr  input  1  write strobe, one cycle per access
- bus_be  input  4  byte enables for writes
- bus_wdata  input  32  write data
- bus_rdata  output  32  read data, valid the cycle after bus_rd
- bus_hit  output  1  combinational: bus_addr is inside the window
- bus_fault  output  1  combinational: hit with misaligned address (bus_addr[1:0]!=0) or unmapped offset
- timer  output  1  registered interrupt level to interrupt controller

Behaviour:
- Register map (offset from BASE_ADDR; word access only):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 EN, other bits read 0
  - 0x14 PRESCALE: 16 bits, upper bits read 0
  - 0x18 MTIME_HI_SNAP: read-only
- Offsets 0x1C–0x3C are unmapped: bus_fault=1, writes ignored, reads return 0.
- Reset values:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, EN=1, PRESCALE=0
  - prescaler counter=0, snapshot=0, bus_rdata=0, timer=0
- Prescaler:
  - 16-bit counter `pcnt`; when EN=1 it increments each cycle.
  - When pcnt==PRESCALE: tick=1 and pcnt←0. Net effect: mtime advances once every PRESCALE+1 cycles.
  - When EN=0: pcnt holds and no ticks occur.
  - Writing PRESCALE clears pcnt.
- mtime increment: 64-bit on tick, carry from LO into HI. Wraps from 2^64−1 to 0 silently.
- Writes:
  - Applied at the clock edge, byte-masked by bus_be.
  - A write to any MTIME half in the same cycle as a tick: the write wins for the written bytes and no increment is applied that cycle to either half.
- Reads:
  - bus_rdata is registered: data for the read of cycle N is presented in cycle N+1.
  - bus_rdata holds its last value when no read occurs.
  - Reading MTIME_LO latches the current MTIME_HI into the snapshot register in the same edge.
  - MTIME_HI_SNAP returns that snapshot; MTIME_HI returns the live value.
  - Software reads LO then SNAP to obtain a tear-free 64-bit value.
- Timer level:
  - timer ← EN && (mtime >= mtimecmp), unsigned 64-bit compare.
  - Registered, so it reflects register state one cycle after any change.
  - Clears one cycle after mtimecmp is written above mtime.
  - Clearing EN deasserts timer on the next cycle.
- No wait states: bus_rd and bus_wr complete in one cycle.
- bus_rd and bus_wr together in the same cycle: the write is applied and bus_rdata returns pre-write data.
- Reset mid-operation clears all state immediately; it is asynchronous.

Decomposition:
- Shared package: MTIMER offset constants, CTRL bit positions, reset values of mtimecmp and PRESCALE. Place these beside the existing CSR/ISA macro headers.
- One natural sub-module: `mtimer_prescaler` (counter, tick output, clear input, enable).

Test Plan:
- Reset, idle 10 cycles with PRESCALE=0 → MTIME_LO reads 10±1 (read latency accounted), timer=0.
- Write MTIMECMP_HI=0, MTIMECMP_LO=20 → timer rises exactly one cycle after mtime reaches 20. Then write MTIMECMP_LO=0xFFFF_FFFF → timer falls the following cycle.
- Write PRESCALE=3, sample mtime over 40 cycles → increments by exactly 10. Write EN=0 → mtime frozen and timer=0.
- Write MTIME_LO=0xFFFF_FFFE, MTIME_HI=0x1 → after 2 ticks LO=0, HI=2. Repeat with HI=0xFFFF_FFFF → wraps to 64'h0.
- Write MTIME_LO with bus_be=4'b0011 and data 0xAAAA_5555 in a tick cycle → LO[15:0]=0x5555, LO[31:16] unchanged, no increment that cycle.
- Read LO at value 0xFFFF_FFFF/HI=7, then read SNAP after the carry → SNAP=7 while MTIME_HI reads 8.
- Access offset 0x20 or address BASE+0x2 → bus_fault=1, no register changes.
